// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter that shares one OLED SPI word writer among N_REQ requesters, with burst LOCK.
// Optional WRITE_DONE timeout is built in when OLED_ARB_TIMEOUT_EN is defined.
module oled_spi_arbiter #(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned DW             = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ-1:0]    LOCK,
  input  logic [N_REQ*DW-1:0] REQ_DATA,
  output logic [N_REQ-1:0]    REQ_DONE,
  output logic [N_REQ-1:0]    GRANT,
  output logic [N_REQ-1:0]    ERR,
  output logic                WRITE_START,
  output logic [DW-1:0]       WRITE_DATA,
  input  logic                WRITE_DONE,
  output logic                BUSY
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DW-1:0] DATA_RST = {2'b11, {(DW-2){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t         state;
  logic [IW-1:0]  rr_last;     // last winner; also the owner while a grant or lock is live
  logic           lock_valid;

  logic           lock_hold;
  logic           win;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  cand;
  logic [DW-1:0]  win_data;

`ifdef OLED_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;
`endif

  // Winner selection: a held lock restricts eligibility to the owner, else round-robin after rr_last.
  always_comb begin
    lock_hold = lock_valid && LOCK[rr_last];
    win       = 1'b0;
    win_idx   = rr_last;
    cand      = '0;
    if (lock_hold) begin
      win = REQ[rr_last];
    end else begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        cand = IW'((32'(rr_last) + k) % N_REQ);
        if (!win && REQ[cand]) begin
          win     = 1'b1;
          win_idx = cand;
        end
      end
    end
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == win_idx) win_data = REQ_DATA[DW*i +: DW];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      GRANT       <= '0;
      WRITE_START <= 1'b0;
      WRITE_DATA  <= DATA_RST;
      REQ_DONE    <= '0;
      ERR         <= '0;
      BUSY        <= 1'b0;
      lock_valid  <= 1'b0;
      rr_last     <= IW'(N_REQ - 1);
`ifdef OLED_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      REQ_DONE <= '0;
      ERR      <= '0;
      case (state)
        IDLE: begin
          if (win) begin
            GRANT       <= N_REQ'(1) << win_idx;
            WRITE_DATA  <= win_data;
            WRITE_START <= 1'b1;
            rr_last     <= win_idx;
            lock_valid  <= lock_hold;
            BUSY        <= 1'b1;
            state       <= ISSUE;
`ifdef OLED_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end else if (lock_hold) begin
            BUSY <= 1'b1;
          end else begin
            lock_valid <= 1'b0;
            GRANT      <= '0;
            BUSY       <= 1'b0;
          end
        end
        ISSUE: begin
          BUSY <= 1'b1;
          if (WRITE_DONE) begin
            WRITE_START <= 1'b0;
            REQ_DONE    <= GRANT;
            lock_valid  <= LOCK[rr_last];
            if (!LOCK[rr_last]) GRANT <= '0;
            state       <= RELEASE;
          end
`ifdef OLED_ARB_TIMEOUT_EN
          // Abort a stuck write; a coincident WRITE_DONE takes the branch above.
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            WRITE_START <= 1'b0;
            REQ_DONE    <= GRANT;
            ERR         <= GRANT;
            lock_valid  <= 1'b0;
            GRANT       <= '0;
            state       <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        RELEASE: begin
          BUSY  <= lock_valid;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Randomized self-checking bench for oled_spi_arbiter; expected service order comes from a queue model.
// Define OLED_ARB_TIMEOUT_EN to also exercise the write-done timeout.
module tb_oled_spi_arbiter;

  localparam int N_REQ = 3;
  localparam int DW    = 10;
  localparam int TMO   = 16;
  localparam int MAXW  = 8;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [N_REQ-1:0]    REQ, LOCK;
  logic [N_REQ*DW-1:0] REQ_DATA;
  logic [N_REQ-1:0]    REQ_DONE, GRANT, ERR;
  logic                WRITE_START;
  logic [DW-1:0]       WRITE_DATA;
  logic                WRITE_DONE;
  logic                BUSY;

  int total = 0;
  int bad   = 0;

  int q_word [N_REQ][MAXW];
  bit q_lock [N_REQ][MAXW];
  int q_len  [N_REQ];
  int q_ptr  [N_REQ];
  int m_rr;
  int exp_g[$];
  int exp_w[$];
  bit exp_l[$];

  oled_spi_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LOCK(LOCK), .REQ_DATA(REQ_DATA),
    .REQ_DONE(REQ_DONE), .GRANT(GRANT), .ERR(ERR), .WRITE_START(WRITE_START),
    .WRITE_DATA(WRITE_DATA), .WRITE_DONE(WRITE_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N_REQ-1:0] oh(input int g);
    logic [N_REQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < N_REQ; i++) begin q_len[i] = 0; q_ptr[i] = 0; end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      if (q_ptr[i] < q_len[i]) begin
        REQ[i]                = 1'b1;
        LOCK[i]               = q_lock[i][q_ptr[i]];
        REQ_DATA[DW*i +: DW]  = DW'(q_word[i][q_ptr[i]]);
      end else begin
        REQ[i]                = 1'b0;
        LOCK[i]               = 1'b0;
        REQ_DATA[DW*i +: DW]  = '0;
      end
    end
  endtask

  // Requesters present the loaded queues from inside reset; the model restarts its pointer.
  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    WRITE_DONE = 1'b0;
    for (int i = 0; i < N_REQ; i++) q_ptr[i] = 0;
    drive_reqs();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    m_rr = N_REQ - 1;
  endtask

  // Reference: service order from queue contents, round-robin with lock continuation.
  task automatic build_expect(input bit tmo_mode);
    int p[N_REQ];
    int nw, g, j;
    bit found, lock_prev;
    exp_g.delete(); exp_w.delete(); exp_l.delete();
    nw = 0;
    lock_prev = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin p[i] = 0; nw += q_len[i]; end
    for (int n = 0; n < nw; n++) begin
      found = 1'b0;
      g = 0;
      if (lock_prev && p[m_rr] < q_len[m_rr] && q_lock[m_rr][p[m_rr]]) begin
        g = m_rr; found = 1'b1;
      end
      for (int k = 1; k <= N_REQ; k++) begin
        j = (m_rr + k) % N_REQ;
        if (!found && p[j] < q_len[j]) begin g = j; found = 1'b1; end
      end
      exp_g.push_back(g);
      exp_w.push_back(q_word[g][p[g]]);
      exp_l.push_back(q_lock[g][p[g]]);
      lock_prev = q_lock[g][p[g]] && !tmo_mode;
      m_rr = g;
      p[g]++;
    end
  endtask

  // lat: writer latency in cycles, 0 = never completes, -1 = random 1..6 per word.
  task automatic run_traffic(input int lat, input bit tmo_mode, input bit chk_lat, input string tag);
    int n_exp, served, cyc, wcnt, cur_lat, start_len, g, w;
    bit l, wsent, prev_start;
    build_expect(tmo_mode);
    n_exp = exp_g.size();
    for (int i = 0; i < N_REQ; i++) q_ptr[i] = 0;
    drive_reqs();
    served = 0; cyc = 0; wcnt = 0; cur_lat = 0; start_len = 0; wsent = 1'b0; prev_start = 1'b0;
    while (served < n_exp && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      WRITE_DONE = 1'b0;
      total++;
      if ($countones(GRANT) > 1) begin
        bad++; $display("FAIL %s grant_onehot: got %b want at most one bit", tag, GRANT);
      end
      if (WRITE_START && !prev_start) begin
        total++;
        if (exp_g.size() == 0) begin
          bad++; $display("FAIL %s extra_write: got data %h want no write", tag, WRITE_DATA);
        end else if (WRITE_DATA !== DW'(exp_w[0]) || GRANT !== oh(exp_g[0]) || BUSY !== 1'b1) begin
          bad++;
          $display("FAIL %s write_issue: got data=%h grant=%b busy=%b want data=%h grant=%b busy=1",
                   tag, WRITE_DATA, GRANT, BUSY, DW'(exp_w[0]), oh(exp_g[0]));
        end
        if (chk_lat && served == 0) begin
          total++;
          if (cyc != 1) begin bad++; $display("FAIL %s start_latency: got %0d want 1", tag, cyc); end
        end
        cur_lat = (lat < 0) ? int'($urandom_range(1, 6)) : lat;
        wcnt = 0; wsent = 1'b0; start_len = 0;
      end
      if (WRITE_START) begin
        start_len++;
        wcnt++;
        if (!wsent && cur_lat != 0 && wcnt == cur_lat) begin WRITE_DONE = 1'b1; wsent = 1'b1; end
      end
      if (REQ_DONE != '0) begin
        total++;
        if (exp_g.size() == 0) begin
          bad++; $display("FAIL %s extra_done: got %b want 000", tag, REQ_DONE);
        end else begin
          g = exp_g.pop_front(); w = exp_w.pop_front(); l = exp_l.pop_front();
          if (REQ_DONE !== oh(g)) begin
            bad++; $display("FAIL %s req_done: got %b want %b (word %h)", tag, REQ_DONE, oh(g), w);
          end
          total++;
          if (ERR !== (tmo_mode ? oh(g) : '0)) begin
            bad++; $display("FAIL %s err_pulse: got %b want %b", tag, ERR, tmo_mode ? oh(g) : '0);
          end
          total++;
          if (GRANT !== ((l && !tmo_mode) ? oh(g) : '0)) begin
            bad++; $display("FAIL %s release_grant: got %b want %b", tag, GRANT, (l && !tmo_mode) ? oh(g) : '0);
          end
          if (tmo_mode) begin
            total++;
            if (start_len != TMO) begin
              bad++; $display("FAIL %s timeout_len: got %0d want %0d", tag, start_len, TMO);
            end
          end
          q_ptr[g]++;
          drive_reqs();
        end
        served++;
      end else begin
        total++;
        if (ERR !== '0) begin bad++; $display("FAIL %s stray_err: got %b want 000", tag, ERR); end
      end
      prev_start = WRITE_START;
    end
    total++;
    if (served < n_exp) begin
      bad++; $display("FAIL %s cycle_budget: got %0d words want %0d", tag, served, n_exp);
    end
    repeat (2) @(negedge CLK);
    total++;
    if (WRITE_START !== 1'b0 || GRANT !== '0 || BUSY !== 1'b0 || REQ_DONE !== '0) begin
      bad++;
      $display("FAIL %s settle: got start=%b grant=%b busy=%b done=%b want 0/000/0/000",
               tag, WRITE_START, GRANT, BUSY, REQ_DONE);
    end
  endtask

  task automatic test_reset();
    clear_queues();
    RST_N = 1'b0; WRITE_DONE = 1'b0;
    drive_reqs();
    @(negedge CLK);
    total++;
    if (GRANT !== '0 || WRITE_START !== 1'b0 || WRITE_DATA !== 10'h300 ||
        REQ_DONE !== '0 || ERR !== '0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got grant=%b start=%b data=%h done=%b err=%b busy=%b want 000/0/300/000/000/0",
               GRANT, WRITE_START, WRITE_DATA, REQ_DONE, ERR, BUSY);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single();
    clear_queues();
    q_len[0] = 1; q_word[0][0] = 10'h0AE; q_lock[0][0] = 1'b0;
    do_reset();
    run_traffic(5, 1'b0, 1'b1, "single");
    // WRITE_DONE while idle must be ignored
    WRITE_DONE = 1'b1;
    @(negedge CLK);
    WRITE_DONE = 1'b0;
    @(negedge CLK);
    total++;
    if (REQ_DONE !== '0 || WRITE_START !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL idle_done_ignored: got done=%b start=%b busy=%b want 000/0/0",
                      REQ_DONE, WRITE_START, BUSY);
    end
  endtask

  task automatic test_contention();
    clear_queues();
    q_len[0] = 2; q_len[1] = 2;
    for (int k = 0; k < 2; k++) begin
      q_word[0][k] = int'($urandom_range(0, 1023)); q_lock[0][k] = 1'b0;
      q_word[1][k] = int'($urandom_range(0, 1023)); q_lock[1][k] = 1'b0;
    end
    do_reset();
    run_traffic(3, 1'b0, 1'b1, "contention");
  endtask

  task automatic test_lock_burst();
    clear_queues();
    q_len[1] = 1; q_word[1][0] = 10'h055; q_lock[1][0] = 1'b0;
    do_reset();
    run_traffic(2, 1'b0, 1'b0, "lock_warmup");
    clear_queues();
    q_len[2] = 2;
    q_word[2][0] = 10'h081; q_lock[2][0] = 1'b1;
    q_word[2][1] = 10'h0FF; q_lock[2][1] = 1'b1;
    q_len[0] = 1; q_word[0][0] = 10'h123; q_lock[0][0] = 1'b0;
    run_traffic(2, 1'b0, 1'b0, "lock_burst");
  endtask

  task automatic test_wrap();
    clear_queues();
    for (int i = 0; i < N_REQ; i++) begin
      q_len[i] = 2;
      for (int k = 0; k < 2; k++) begin
        q_word[i][k] = int'($urandom_range(0, 1023)); q_lock[i][k] = 1'b0;
      end
    end
    do_reset();
    run_traffic(1, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_reset_mid_issue();
    int waited;
    clear_queues();
    q_len[1] = 1; q_word[1][0] = 10'h1AB; q_lock[1][0] = 1'b0;
    do_reset();
    waited = 0;
    while (WRITE_START !== 1'b1 && waited < 10) begin @(negedge CLK); waited++; end
    total++;
    if (WRITE_START !== 1'b1) begin
      bad++; $display("FAIL mid_reset_start: got %b want 1", WRITE_START);
    end
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    total++;
    if (WRITE_START !== 1'b0 || GRANT !== '0 || WRITE_DATA !== 10'h300 || BUSY !== 1'b0) begin
      bad++; $display("FAIL mid_reset_async: got start=%b grant=%b data=%h busy=%b want 0/000/300/0",
                      WRITE_START, GRANT, WRITE_DATA, BUSY);
    end
    clear_queues();
    q_len[0] = 1; q_word[0][0] = 10'h2C3; q_lock[0][0] = 1'b0;
    q_len[1] = 1; q_word[1][0] = 10'h1AB; q_lock[1][0] = 1'b0;
    drive_reqs();
    @(negedge CLK);
    RST_N = 1'b1;
    m_rr = N_REQ - 1;
    run_traffic(2, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_queues();
      for (int i = 0; i < N_REQ; i++) begin
        q_len[i] = int'($urandom_range(0, 4));
        for (int k = 0; k < q_len[i]; k++) begin
          q_word[i][k] = int'($urandom_range(0, 1023));
          q_lock[i][k] = 1'($urandom_range(0, 1));
        end
      end
      do_reset();
      run_traffic(-1, 1'b0, 1'b0, "random");
    end
  endtask

`ifdef OLED_ARB_TIMEOUT_EN
  task automatic test_timeout();
    clear_queues();
    q_len[1] = 1; q_word[1][0] = 10'h0C4; q_lock[1][0] = 1'b0;
    q_len[2] = 1; q_word[2][0] = 10'h33A; q_lock[2][0] = 1'b0;
    do_reset();
    run_traffic(0, 1'b1, 1'b0, "timeout");
  endtask
`endif

  initial begin
    RST_N = 1'b0; REQ = '0; LOCK = '0; REQ_DATA = '0; WRITE_DONE = 1'b0; m_rr = N_REQ - 1;
    test_reset();
    test_single();
    test_contention();
    test_lock_burst();
    test_wrap();
    test_reset_mid_issue();
    test_random();
`ifdef OLED_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
